// File: rtl/pingpong_xfer_engine.sv
// Ping-pong staging buffer to banked SRAM copy engine, single-bank or round-robin striping.
// Optional XFER_STALL_EN adds a stall input that pauses read issue without losing words.
module pingpong_xfer_engine #(
    parameter int DATA_W    = 128,
    parameter int BUF_AW    = 7,
    parameter int SRAM_AW   = 7,
    parameter int NUM_BANKS = 64,
    parameter int BANK_IW   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 buf_sel,
    input  logic [BUF_AW-1:0]    buf_addr_start,
    input  logic [BUF_AW-1:0]    buf_addr_end,
    input  logic [SRAM_AW-1:0]   sram_addr_start,
    input  logic [BANK_IW-1:0]   bank_start,
    input  logic                 bank_mode,
`ifdef XFER_STALL_EN
    input  logic                 stall,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           buf_cen,
    output logic [1:0]           buf_oen,
    output logic [BUF_AW-1:0]    buf_a,
    input  logic [DATA_W-1:0]    buf_do0,
    input  logic [DATA_W-1:0]    buf_do1,
    output logic [NUM_BANKS-1:0] sram_cen,
    output logic [NUM_BANKS-1:0] sram_wen,
    output logic [SRAM_AW-1:0]   sram_a,
    output logic [DATA_W-1:0]    sram_di
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [BANK_IW-1:0] LAST_BANK = BANK_IW'(NUM_BANKS - 1);

    state_t               state_q, state_d;
    logic                 sel_q, sel_d;
    logic                 mode_q, mode_d;
    logic [BUF_AW-1:0]    end_q, end_d;
    logic [BUF_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [SRAM_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [BANK_IW-1:0]   wr_bank_q, wr_bank_d;
    logic                 wr_valid_q, wr_valid_d;
    logic                 err_q, err_d;
    logic                 stall_w;
    logic                 issue;

`ifdef XFER_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign issue = (state_q == S_READ) && !stall_w;

    always_comb begin
        // NOTE: every _d gets its current value first so no path leaves a latch.
        state_d    = state_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        end_d      = end_q;
        rd_ptr_d   = rd_ptr_q;
        wr_addr_d  = wr_addr_q;
        wr_bank_d  = wr_bank_q;
        err_d      = err_q;
        wr_valid_d = issue;

        // Destination advances after each completed write.
        if (wr_valid_q) begin
            if (!mode_q) begin
                wr_addr_d = wr_addr_q + SRAM_AW'(1);
            end else if (wr_bank_q == LAST_BANK) begin
                wr_bank_d = '0;
                wr_addr_d = wr_addr_q + SRAM_AW'(1);
            end else begin
                wr_bank_d = wr_bank_q + BANK_IW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (buf_addr_end >= buf_addr_start) begin
                        sel_d     = buf_sel;
                        mode_d    = bank_mode;
                        end_d     = buf_addr_end;
                        rd_ptr_d  = buf_addr_start;
                        wr_addr_d = sram_addr_start;
                        wr_bank_d = bank_start;
                        err_d     = 1'b0;
                        state_d   = S_READ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + BUF_AW'(1);
                    if (rd_ptr_q == end_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            mode_q     <= 1'b0;
            end_q      <= '0;
            rd_ptr_q   <= '0;
            wr_addr_q  <= '0;
            wr_bank_q  <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            end_q      <= end_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_addr_q  <= wr_addr_d;
            wr_bank_q  <= wr_bank_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        buf_cen = 2'b11;
        buf_oen = 2'b11;
        if (issue) begin
            buf_cen[sel_q] = 1'b0;
            buf_oen[sel_q] = 1'b0;
        end
    end

    assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign buf_a    = rd_ptr_q;
    assign sram_a   = wr_addr_q;
    // Write data is forced to zero outside a write so reset leaves the bus quiet.
    assign sram_di  = wr_valid_q ? (sel_q ? buf_do1 : buf_do0) : '0;
    assign sram_cen = wr_valid_q ? ~(NUM_BANKS'(1) << wr_bank_q) : '1;
    assign sram_wen = sram_cen;

endmodule

// File: tb/tb_pingpong_xfer_engine.sv
// Scoreboard bench for pingpong_xfer_engine: expected bank writes are queued at start
// and matched against every observed SRAM write.
module tb_pingpong_xfer_engine;

    localparam int DATA_W    = 128;
    localparam int BUF_AW    = 7;
    localparam int SRAM_AW   = 7;
    localparam int NUM_BANKS = 64;
    localparam int BANK_IW   = 6;

    typedef struct {
        int                 bank;
        logic [SRAM_AW-1:0] addr;
        logic [DATA_W-1:0]  data;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 buf_sel = 1'b0;
    logic [BUF_AW-1:0]    buf_addr_start = '0;
    logic [BUF_AW-1:0]    buf_addr_end = '0;
    logic [SRAM_AW-1:0]   sram_addr_start = '0;
    logic [BANK_IW-1:0]   bank_start = '0;
    logic                 bank_mode = 1'b0;
    logic                 stall = 1'b0;
    logic                 busy, done, err;
    logic [1:0]           buf_cen, buf_oen;
    logic [BUF_AW-1:0]    buf_a;
    logic [DATA_W-1:0]    buf_do0 = '0;
    logic [DATA_W-1:0]    buf_do1 = '0;
    logic [NUM_BANKS-1:0] sram_cen, sram_wen;
    logic [SRAM_AW-1:0]   sram_a;
    logic [DATA_W-1:0]    sram_di;

    logic [DATA_W-1:0] mem0 [2**BUF_AW];
    logic [DATA_W-1:0] mem1 [2**BUF_AW];
    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  rd_cnt  = 0;
    int  wr_cnt  = 0;
    logic exp_sel = 1'b0;

    pingpong_xfer_engine #(
        .DATA_W(DATA_W), .BUF_AW(BUF_AW), .SRAM_AW(SRAM_AW),
        .NUM_BANKS(NUM_BANKS), .BANK_IW(BANK_IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .buf_sel(buf_sel),
        .buf_addr_start(buf_addr_start), .buf_addr_end(buf_addr_end),
        .sram_addr_start(sram_addr_start), .bank_start(bank_start),
        .bank_mode(bank_mode),
`ifdef XFER_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .done(done), .err(err),
        .buf_cen(buf_cen), .buf_oen(buf_oen), .buf_a(buf_a),
        .buf_do0(buf_do0), .buf_do1(buf_do1),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_di(sram_di)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous staging buffers: data one cycle after an enabled address.
    always @(posedge clk) begin
        if (!buf_cen[0] && !buf_oen[0]) buf_do0 <= mem0[buf_a];
        if (!buf_cen[1] && !buf_oen[1]) buf_do1 <= mem1[buf_a];
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && buf_cen != 2'b11) begin
            rd_cnt++;
            check("buf_cen", buf_cen, exp_sel ? 2'b01 : 2'b10);
            check("buf_oen", buf_oen, buf_cen);
        end
        if (!rst && sram_cen != '1) begin
            wr_t w;
            int  b;
            wr_cnt++;
            b = -1;
            for (int i = 0; i < NUM_BANKS; i++) if (!sram_cen[i]) b = i;
            check("wr_onehot", $countones(~sram_cen), 1);
            check("wr_wen", sram_wen, sram_cen);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("wr_bank", b, w.bank);
                check("wr_addr", sram_a, w.addr);
                check("wr_data", sram_di, w.data);
            end
        end
    end

    task automatic push_model(input logic sel, input int s, input int e,
                              input int sa, input int bs, input logic mode);
        int bank = bs;
        int addr = sa;
        for (int i = s; i <= e; i++) begin
            wr_t w;
            w.bank = bank;
            w.addr = SRAM_AW'(addr);
            w.data = sel ? mem1[i] : mem0[i];
            exp_q.push_back(w);
            if (!mode) begin
                addr = (addr + 1) % (2**SRAM_AW);
            end else if (bank == NUM_BANKS - 1) begin
                bank = 0;
                addr = (addr + 1) % (2**SRAM_AW);
            end else begin
                bank++;
            end
        end
    endtask

    // poke: extra start pulses while busy and in the DONE cycle.
    // stall_test: stall high for the three cycles after the second read.
    task automatic run_xfer(input string name, input logic sel, input int s, input int e,
                            input int sa, input int bs, input logic mode,
                            input bit poke, input bit stall_test, input bit exp_err);
        int   t0, done_cyc, n, rd0, wr0, extra;
        bit   seen;
        n     = (e >= s) ? e - s + 1 : 0;
        extra = stall_test ? 3 : 0;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        buf_sel = sel;
        buf_addr_start = BUF_AW'(s);
        buf_addr_end = BUF_AW'(e);
        sram_addr_start = SRAM_AW'(sa);
        bank_start = BANK_IW'(bs);
        bank_mode = mode;
        start = 1'b1;
        exp_sel = sel;
        t0 = cyc;
        if (n > 0) push_model(sel, s, e, sa, bs, mode);
        seen = 0;
        done_cyc = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                buf_sel = ~sel;
                buf_addr_start = 7'd0;
                buf_addr_end = 7'd3;
                sram_addr_start = 7'h55;
                bank_start = 6'd7;
                bank_mode = ~mode;
            end
            start = 1'b0;
            if (stall_test) stall = (i >= 2 && i < 5);
            if (done) begin
                seen = 1;
                done_cyc = cyc;
                if (poke) start = 1'b1;
            end else if (poke && i == 2) begin
                start = 1'b1;
            end
        end
        if (!seen) check({name, "_done_timeout"}, 0, 1);
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        repeat (5) @(negedge clk);
        if (seen) check({name, "_latency"}, done_cyc - t0, exp_err ? 1 : n + 2 + extra);
        check({name, "_busy_idle"}, busy, 0);
        check({name, "_err"}, err, exp_err);
        check({name, "_reads"}, rd_cnt - rd0, n);
        check({name, "_writes"}, wr_cnt - wr0, n);
        check({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 2**BUF_AW; i++) begin
            mem0[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem1[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_buf_cen", buf_cen, 2'b11);
        check("rst_buf_oen", buf_oen, 2'b11);
        check("rst_sram_cen", sram_cen, {NUM_BANKS{1'b1}});
        check("rst_sram_wen", sram_wen, {NUM_BANKS{1'b1}});
        check("rst_buf_a", buf_a, 0);
        check("rst_sram_a", sram_a, 0);
        check("rst_sram_di", sram_di, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_xfer("m0_basic",   1'b0, 5,   9,   3,   2,  1'b0, 0, 0, 0);
        run_xfer("m1_stripe",  1'b1, 0,   3,   10,  62, 1'b1, 0, 0, 0);
        run_xfer("range_err",  1'b0, 20,  10,  0,   0,  1'b0, 0, 0, 1);
        run_xfer("err_clear",  1'b1, 0,   1,   0,   5,  1'b0, 0, 0, 0);
        run_xfer("end_max",    1'b0, 125, 127, 127, 63, 1'b1, 0, 0, 0);
        run_xfer("addr_wrap",  1'b1, 40,  42,  126, 9,  1'b0, 0, 0, 0);
        run_xfer("ignore_st",  1'b0, 60,  65,  20,  30, 1'b1, 1, 0, 0);

        // Asynchronous reset part-way through a full-depth transfer.
        @(negedge clk);
        buf_sel = 1'b0;
        buf_addr_start = 7'd0;
        buf_addr_end = 7'd127;
        sram_addr_start = 7'd0;
        bank_start = 6'd0;
        bank_mode = 1'b1;
        exp_sel = 1'b0;
        start = 1'b1;
        push_model(1'b0, 0, 127, 0, 0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_buf_cen", buf_cen, 2'b11);
        check("mid_rst_sram_cen", sram_cen, {NUM_BANKS{1'b1}});
        check("mid_rst_sram_wen", sram_wen, {NUM_BANKS{1'b1}});
        check("mid_rst_sram_di", sram_di, 0);
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        run_xfer("after_rst",  1'b0, 0,   0,   4,   11, 1'b0, 0, 0, 0);
`ifdef XFER_STALL_EN
        run_xfer("stall",      1'b1, 8,   11,  50,  1,  1'b0, 0, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
